ysyx_22040125_alu_arb: RTL and testbench
========================================

YSYX_22040125_ALU_ARB -- requirements
Module: ysyx_22040125_alu_arb

Interface
REQ-001 Parameter: TAG_W, default 4, width of the requester transaction tag.
REQ-002 Port: clk  input  1  single clock, all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: r0_valid / r0_ready  input / output  1 / 1  execute-stage request handshake.
REQ-005 Port: r0_src1, r0_src2 / r0_op / r0_tag  input  64 / 12 / TAG_W  execute-stage operands, one-hot ALU op, tag.
REQ-006 Port: r1_valid / r1_ready  input / output  1 / 1  load/store address-generation request handshake.
REQ-007 Port: r1_src1, r1_src2 / r1_op / r1_tag  input  64 / 12 / TAG_W  address-generation operands, op, tag.
REQ-008 Port: o_valid / o_ready  output / input  1 / 1  result handshake toward writeback/LSU.
REQ-009 Port: o_data / o_addr  output  64 / 32  ALU result; o_addr = o_data[31:0].
REQ-010 Port: o_id / o_tag / o_err  output  1 / TAG_W / 1  winning requester (0/1), its tag, illegal-op flag.

Function
REQ-011 Op encoding: bit0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 or, 6 xor, 7 sll, 8 srl, 9 sra, 10 lui (result = src2), 11 jal (result = src1+4).
REQ-012 All results full 64-bit; shifts use src2[5:0]; slt/sltu yield 64'd0 or 64'd1.
REQ-013 Output stage has two states: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-014 Accept-enable acc = EMPTY or (FULL and o_ready); a transfer occurs on rN_valid & rN_ready.
REQ-015 At most one requester granted per cycle; rN_ready=1 only for the granted requester and only when acc=1.
REQ-016 Arbitration round-robin: if both valid, grant the requester not granted most recently; if one valid, grant it.
REQ-017 last_grant updates only on an actual transfer; no transfer leaves it unchanged.
REQ-018 rN_ready is combinational from rN_valid, last_grant, state, o_ready; no valid depends on ready.
REQ-019 Latency: result, id, tag registered; o_valid asserts the cycle after acceptance.
REQ-020 Throughput: one result per cycle while o_ready=1 and a requester is valid (back-to-back, no bubble).
REQ-021 FULL and o_ready=0: o_* held stable, both rN_ready=0.
REQ-022 FULL and o_ready=1 with no transfer: next state EMPTY.
REQ-023 Op with zero or more than one bit set: accepted normally, o_data=64'd0, o_err=1; otherwise o_err=0.
REQ-024 Requester inputs sampled only in the transfer cycle; later changes do not affect the held result.

Reset
REQ-025 rst=1 at a clock edge: state EMPTY, o_valid=0, o_data=0, o_id=0, o_tag=0, o_err=0, last_grant=1 (so requester 0 wins first tie).
REQ-026 Reset mid-transaction discards the held result; rN_ready=0 while rst=1.

Structure
REQ-027 Op bit indices (REQ-011) and the op width 12 live in the shared core package used by decode and ALU.
REQ-028 Combinational datapath is one instance of the team ALU sub-module ysyx_22040125_ALU, fed by the grant mux.
REQ-029 Arbiter, output register and FSM reside in this module; no further sub-modules.

Verification
REQ-030 Reset, then r0 add src1=5, src2=7, tag=3, o_ready=1 -> next cycle o_valid=1, o_data=12, o_id=0, o_tag=3.
REQ-031 Both valid every cycle, o_ready=1 -> grants alternate 0,1,0,1 starting with 0, one o_valid per cycle.
REQ-032 r1 sub src1=0x1_0000_0000, src2=1 -> o_data=0x0000_0000_FFFF_FFFF, o_addr=0xFFFF_FFFF (upper word checked).
REQ-033 Result held with o_ready=0 for 3 cycles -> o_* stable, r0_ready=r1_ready=0; o_ready=1 -> new request accepted the same cycle.
REQ-034 r0 op=12'b0000_0000_0011 -> o_err=1, o_data=0; following sra src1=0x8000_0000_0000_0000, src2=63 -> o_data=all ones, o_err=0.
REQ-035 rst asserted while FULL -> next cycle o_valid=0; first tie after reset granted to requester 0.

Source files
------------

// File: rtl/ysyx_22040125_alu_arb_pkg.sv
// Shared core package: ALU op encoding, datapath widths, output-stage state type.
package ysyx_22040125_alu_arb_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OP_W   = 12;

  // One-hot op bit positions
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_SLT  = 2;
  localparam int unsigned OP_SLTU = 3;
  localparam int unsigned OP_AND  = 4;
  localparam int unsigned OP_OR   = 5;
  localparam int unsigned OP_XOR  = 6;
  localparam int unsigned OP_SLL  = 7;
  localparam int unsigned OP_SRL  = 8;
  localparam int unsigned OP_SRA  = 9;
  localparam int unsigned OP_LUI  = 10;
  localparam int unsigned OP_JAL  = 11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // True when exactly one op bit is set
  function automatic logic op_is_onehot(input logic [OP_W-1:0] op);
    return (op != '0) && ((op & (op - OP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ysyx_22040125_alu_arb_alu.sv
// Team ALU: purely combinational 64-bit datapath driven by a one-hot op.
//   src1, src2 : operands
//   op         : one-hot operation select
//   result_c   : result (zero for an illegal op)
//   err_c      : op has zero or multiple bits set
module ysyx_22040125_ALU
  import ysyx_22040125_alu_arb_pkg::*;
(
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [OP_W-1:0] op,
  output logic [XLEN-1:0] result_c,
  output logic            err_c
);

  logic [5:0] shamt;
  assign shamt = src2[5:0];

  // Result select; illegal ops force zero
  always_comb begin
    result_c = '0;
    err_c    = !op_is_onehot(op);
    if (!err_c) begin
      case (1'b1)
        op[OP_ADD]:  result_c = src1 + src2;
        op[OP_SUB]:  result_c = src1 - src2;
        op[OP_SLT]:  result_c = XLEN'($signed(src1) < $signed(src2));
        op[OP_SLTU]: result_c = XLEN'(src1 < src2);
        op[OP_AND]:  result_c = src1 & src2;
        op[OP_OR]:   result_c = src1 | src2;
        op[OP_XOR]:  result_c = src1 ^ src2;
        op[OP_SLL]:  result_c = src1 << shamt;
        op[OP_SRL]:  result_c = src1 >> shamt;
        op[OP_SRA]:  result_c = XLEN'($signed(src1) >>> shamt);
        op[OP_LUI]:  result_c = src2;
        op[OP_JAL]:  result_c = src1 + XLEN'(4);
        default:     result_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22040125_alu_arb.sv
// Two-requester round-robin arbiter in front of one shared ALU, with a
// single registered output slot.
//   clk, rst                  : clock, synchronous active-high reset
//   r0_* (execute stage)      : valid/ready handshake, operands, op, tag
//   r1_* (address generation) : valid/ready handshake, operands, op, tag
//   o_valid/o_ready           : result handshake
//   o_data/o_addr             : result and its low 32 bits
//   o_id/o_tag/o_err          : winning requester, its tag, illegal-op flag
module ysyx_22040125_alu_arb
  import ysyx_22040125_alu_arb_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [XLEN-1:0]   r0_src1,
  input  logic [XLEN-1:0]   r0_src2,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [TAG_W-1:0]  r0_tag,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [XLEN-1:0]   r1_src1,
  input  logic [XLEN-1:0]   r1_src2,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [TAG_W-1:0]  r1_tag,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [XLEN-1:0]   o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_id,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_err
);

  state_t             state;
  logic               last_grant;
  logic               acc;
  logic               grant1;
  logic               xfer;
  logic [XLEN-1:0]    mux_src1;
  logic [XLEN-1:0]    mux_src2;
  logic [OP_W-1:0]    mux_op;
  logic [TAG_W-1:0]   mux_tag;
  logic [XLEN-1:0]    alu_result_c;
  logic               alu_err_c;

  // Round-robin grant: on a tie, r1 wins only if r0 was granted last
  always_comb begin
    acc      = (state == ST_EMPTY) || o_ready;
    grant1   = r1_valid && (!r0_valid || !last_grant);
    r0_ready = !rst && acc && r0_valid && !grant1;
    r1_ready = !rst && acc && grant1;
    xfer     = r0_ready || r1_ready;
    mux_src1 = grant1 ? r1_src1 : r0_src1;
    mux_src2 = grant1 ? r1_src2 : r0_src2;
    mux_op   = grant1 ? r1_op   : r0_op;
    mux_tag  = grant1 ? r1_tag  : r0_tag;
  end

  ysyx_22040125_ALU u_alu (
    .src1     (mux_src1),
    .src2     (mux_src2),
    .op       (mux_op),
    .result_c (alu_result_c),
    .err_c    (alu_err_c)
  );

  // Output slot FSM and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      o_data     <= '0;
      o_id       <= 1'b0;
      o_tag      <= '0;
      o_err      <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      state      <= ST_FULL;
      o_data     <= alu_result_c;
      o_id       <= grant1;
      o_tag      <= mux_tag;
      o_err      <= alu_err_c;
      last_grant <= grant1;
    end else if ((state == ST_FULL) && o_ready) begin
      state      <= ST_EMPTY;
    end
  end

  assign o_valid = (state == ST_FULL);
  assign o_addr  = o_data[ADDR_W-1:0];

endmodule

// File: tb/tb_ysyx_22040125_alu_arb.sv
module tb_ysyx_22040125_alu_arb;

  localparam int unsigned TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_valid, r0_ready, r1_valid, r1_ready;
  logic [63:0]       r0_src1, r0_src2, r1_src1, r1_src2;
  logic [11:0]       r0_op, r1_op;
  logic [TAG_W-1:0]  r0_tag, r1_tag;
  logic              o_valid, o_ready, o_id, o_err;
  logic [63:0]       o_data;
  logic [31:0]       o_addr;
  logic [TAG_W-1:0]  o_tag;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit               m_full, m_id, m_err, m_last, m_win, m_xfer;
  logic [63:0]      m_data;
  logic [TAG_W-1:0] m_tag;
  bit               exp_r0_rdy, exp_r1_rdy, obs_r0_rdy, obs_r1_rdy;

  always #5 clk = ~clk;

  ysyx_22040125_alu_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_src1(r0_src1), .r0_src2(r0_src2),
    .r0_op(r0_op), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_src1(r1_src1), .r1_src2(r1_src2),
    .r1_op(r1_op), .r1_tag(r1_tag),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_addr(o_addr),
    .o_id(o_id), .o_tag(o_tag), .o_err(o_err)
  );

  // Returns {err, result}
  function automatic logic [64:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [11:0] op);
    int idx;
    logic signed [63:0] sa;
    sa  = a;
    idx = -1;
    if ($countones(op) != 1) return {1'b1, 64'd0};
    for (int i = 0; i < 12; i++) if (op[i]) idx = i;
    case (idx)
      0:  return {1'b0, a + b};
      1:  return {1'b0, a - b};
      2:  return {1'b0, 63'd0, ($signed(a) < $signed(b))};
      3:  return {1'b0, 63'd0, (a < b)};
      4:  return {1'b0, a & b};
      5:  return {1'b0, a | b};
      6:  return {1'b0, a ^ b};
      7:  return {1'b0, a << b[5:0]};
      8:  return {1'b0, a >> b[5:0]};
      9:  return {1'b0, sa >>> b[5:0]};
      10: return {1'b0, b};
      11: return {1'b0, a + 64'd4};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  function automatic logic [11:0] rand_onehot();
    logic [11:0] one;
    one = 12'h001;
    return one << $urandom_range(0, 11);
  endfunction

  task automatic set_r0(input bit v, input logic [63:0] a, input logic [63:0] b,
                        input logic [11:0] op, input logic [TAG_W-1:0] tag);
    r0_valid = v; r0_src1 = a; r0_src2 = b; r0_op = op; r0_tag = tag;
  endtask

  task automatic set_r1(input bit v, input logic [63:0] a, input logic [63:0] b,
                        input logic [11:0] op, input logic [TAG_W-1:0] tag);
    r1_valid = v; r1_src1 = a; r1_src2 = b; r1_op = op; r1_tag = tag;
  endtask

  task automatic idle();
    set_r0(0, {$urandom, $urandom}, {$urandom, $urandom}, rand_onehot(), 4'($urandom));
    set_r1(0, {$urandom, $urandom}, {$urandom, $urandom}, rand_onehot(), 4'($urandom));
  endtask

  // Sample readies mid-cycle, advance one clock, update the model
  task automatic tick();
    bit        acc_m;
    logic [64:0] r;
    @(negedge clk);
    obs_r0_rdy = r0_ready;
    obs_r1_rdy = r1_ready;
    if (r0_valid && r1_valid) m_win = !m_last;
    else                      m_win = r1_valid;
    acc_m      = !m_full || o_ready;
    exp_r0_rdy = !rst && acc_m && r0_valid && !m_win;
    exp_r1_rdy = !rst && acc_m && r1_valid && m_win;
    m_xfer     = exp_r0_rdy || exp_r1_rdy;
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_data = '0; m_id = 0; m_tag = '0; m_err = 0; m_last = 1;
    end else if (m_xfer) begin
      r      = m_win ? ref_alu(r1_src1, r1_src2, r1_op) : ref_alu(r0_src1, r0_src2, r0_op);
      m_err  = r[64];
      m_data = r[63:0];
      m_id   = m_win;
      m_tag  = m_win ? r1_tag : r0_tag;
      m_last = m_win;
      m_full = 1;
    end else if (m_full && o_ready) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; o_ready = 1;
    set_r0(1, 64'd1, 64'd2, 12'h001, 4'd1);
    set_r1(1, 64'd3, 64'd4, 12'h001, 4'd2);
    tick();
    checks++; if (obs_r0_rdy !== 1'b0 || obs_r1_rdy !== 1'b0) begin failures++;
      $display("FAIL reset_ready: r0_ready=%0b r1_ready=%0b expected 0/0", obs_r0_rdy, obs_r1_rdy); end
    checks++; if (o_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid: o_valid=%0b expected 0", o_valid); end
    checks++; if (o_data !== 64'd0 || o_id !== 1'b0 || o_tag !== 4'd0 || o_err !== 1'b0) begin failures++;
      $display("FAIL reset_regs: data=%h id=%0b tag=%0d err=%0b expected zeros", o_data, o_id, o_tag, o_err); end
    rst = 0; idle(); tick();
  endtask

  task automatic test_add();
    do_reset(); o_ready = 1;
    set_r0(1, 64'd5, 64'd7, 12'h001, 4'd3);
    tick(); idle();
    checks++; if (obs_r0_rdy !== 1'b1 || obs_r1_rdy !== 1'b0) begin failures++;
      $display("FAIL add_ready: r0_ready=%0b r1_ready=%0b expected 1/0", obs_r0_rdy, obs_r1_rdy); end
    checks++; if (o_valid !== 1'b1 || o_data !== 64'd12 || o_id !== 1'b0 || o_tag !== 4'd3 || o_err !== 1'b0)
      begin failures++;
      $display("FAIL add_result: valid=%0b data=%0d id=%0b tag=%0d err=%0b expected 1/12/0/3/0",
               o_valid, o_data, o_id, o_tag, o_err); end
    checks++; if (o_addr !== 32'd12) begin failures++;
      $display("FAIL add_addr: o_addr=%h expected 0000000c", o_addr); end
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++;
      $display("FAIL drain_empty: o_valid=%0b expected 0", o_valid); end
  endtask

  task automatic test_alternate();
    do_reset(); o_ready = 1;
    for (int k = 0; k < 8; k++) begin
      set_r0(1, {$urandom, $urandom}, {$urandom, $urandom}, rand_onehot(), 4'($urandom));
      set_r1(1, {$urandom, $urandom}, {$urandom, $urandom}, rand_onehot(), 4'($urandom));
      tick();
      checks++; if (o_valid !== 1'b1 || o_id !== 1'(k % 2)) begin failures++;
        $display("FAIL alternate[%0d]: valid=%0b id=%0b expected 1/%0d", k, o_valid, o_id, k % 2); end
      checks++; if (o_data !== m_data || o_tag !== m_tag || o_err !== m_err) begin failures++;
        $display("FAIL alternate_data[%0d]: data=%h tag=%0d err=%0b expected %h/%0d/%0b",
                 k, o_data, o_tag, o_err, m_data, m_tag, m_err); end
    end
    idle(); tick();
  endtask

  task automatic test_sub_upper();
    o_ready = 1; idle();
    set_r1(1, 64'h1_0000_0000, 64'd1, 12'h002, 4'd5);
    tick(); idle();
    checks++; if (o_data !== 64'h0000_0000_FFFF_FFFF || o_addr !== 32'hFFFF_FFFF || o_id !== 1'b1)
      begin failures++;
      $display("FAIL sub_upper: data=%h addr=%h id=%0b expected 00000000ffffffff/ffffffff/1",
               o_data, o_addr, o_id); end
    tick();
  endtask

  task automatic test_hold();
    logic [63:0] h_data; logic h_id; logic [TAG_W-1:0] h_tag; logic h_err;
    o_ready = 1; idle();
    set_r0(1, {$urandom, $urandom}, {$urandom, $urandom}, 12'h001, 4'($urandom));
    tick();
    h_data = m_data; h_id = m_id; h_tag = m_tag; h_err = m_err;
    o_ready = 0;
    for (int k = 0; k < 3; k++) begin
      set_r0(1, {$urandom, $urandom}, {$urandom, $urandom}, rand_onehot(), 4'($urandom));
      set_r1(1, {$urandom, $urandom}, {$urandom, $urandom}, rand_onehot(), 4'($urandom));
      tick();
      checks++; if (obs_r0_rdy !== 1'b0 || obs_r1_rdy !== 1'b0) begin failures++;
        $display("FAIL hold_ready[%0d]: r0_ready=%0b r1_ready=%0b expected 0/0", k, obs_r0_rdy, obs_r1_rdy); end
      checks++; if (o_valid !== 1'b1 || o_data !== h_data || o_id !== h_id || o_tag !== h_tag || o_err !== h_err)
        begin failures++;
        $display("FAIL hold_stable[%0d]: valid=%0b data=%h id=%0b tag=%0d expected 1/%h/%0b/%0d",
                 k, o_valid, o_data, o_id, o_tag, h_data, h_id, h_tag); end
    end
    o_ready = 1;
    set_r0(1, 64'd100, 64'd23, 12'h002, 4'd9);
    set_r1(1, 64'd50, 64'd8, 12'h001, 4'd10);
    tick(); idle();
    checks++; if (obs_r0_rdy !== exp_r0_rdy || obs_r1_rdy !== exp_r1_rdy || !(exp_r0_rdy || exp_r1_rdy))
      begin failures++;
      $display("FAIL release_ready: r0_ready=%0b r1_ready=%0b expected %0b/%0b",
               obs_r0_rdy, obs_r1_rdy, exp_r0_rdy, exp_r1_rdy); end
    checks++; if (o_valid !== 1'b1 || o_data !== m_data || o_id !== m_id || o_tag !== m_tag) begin failures++;
      $display("FAIL release_data: valid=%0b data=%h id=%0b tag=%0d expected 1/%h/%0b/%0d",
               o_valid, o_data, o_id, o_tag, m_data, m_id, m_tag); end
    tick();
  endtask

  task automatic test_err();
    o_ready = 1; idle();
    set_r0(1, {$urandom, $urandom}, {$urandom, $urandom}, 12'b0000_0000_0011, 4'd7);
    tick();
    set_r0(1, 64'h8000_0000_0000_0000, 64'd63, 12'h200, 4'd2);
    checks++; if (o_valid !== 1'b1 || o_err !== 1'b1 || o_data !== 64'd0) begin failures++;
      $display("FAIL err_multi: valid=%0b err=%0b data=%h expected 1/1/0", o_valid, o_err, o_data); end
    tick();
    set_r0(1, 64'd9, 64'd9, 12'h000, 4'd1);
    checks++; if (o_err !== 1'b0 || o_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++;
      $display("FAIL sra_63: err=%0b data=%h expected 0/ffffffffffffffff", o_err, o_data); end
    tick(); idle();
    checks++; if (o_valid !== 1'b1 || o_err !== 1'b1 || o_data !== 64'd0) begin failures++;
      $display("FAIL err_zero: valid=%0b err=%0b data=%h expected 1/1/0", o_valid, o_err, o_data); end
    tick();
  endtask

  task automatic test_reset_full();
    o_ready = 1; idle();
    set_r0(1, 64'd1, 64'd1, 12'h001, 4'd4);
    tick();
    o_ready = 0; rst = 1;
    set_r0(1, 64'd2, 64'd2, 12'h001, 4'd5);
    set_r1(1, 64'd3, 64'd3, 12'h001, 4'd6);
    tick();
    checks++; if (o_valid !== 1'b0 || obs_r0_rdy !== 1'b0 || obs_r1_rdy !== 1'b0) begin failures++;
      $display("FAIL reset_full: valid=%0b r0_ready=%0b r1_ready=%0b expected 0/0/0",
               o_valid, obs_r0_rdy, obs_r1_rdy); end
    rst = 0; o_ready = 1;
    tick(); idle();
    checks++; if (o_valid !== 1'b1 || o_id !== 1'b0 || o_data !== 64'd4 || o_tag !== 4'd5) begin failures++;
      $display("FAIL reset_tie: valid=%0b id=%0b data=%0d tag=%0d expected 1/0/4/5",
               o_valid, o_id, o_data, o_tag); end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] op0, op1;
    for (int k = 0; k < 400; k++) begin
      o_ready = ($urandom_range(0, 3) != 0);
      op0 = ($urandom_range(0, 7) == 0) ? 12'($urandom) : rand_onehot();
      op1 = ($urandom_range(0, 7) == 0) ? 12'($urandom) : rand_onehot();
      set_r0(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, op0, 4'($urandom));
      set_r1(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, op1, 4'($urandom));
      tick();
      checks++; if (obs_r0_rdy !== exp_r0_rdy || obs_r1_rdy !== exp_r1_rdy) begin failures++;
        $display("FAIL rand_ready[%0d]: r0_ready=%0b r1_ready=%0b expected %0b/%0b",
                 k, obs_r0_rdy, obs_r1_rdy, exp_r0_rdy, exp_r1_rdy); end
      checks++; if (o_valid !== m_full) begin failures++;
        $display("FAIL rand_valid[%0d]: o_valid=%0b expected %0b", k, o_valid, m_full); end
      if (m_full) begin
        checks++;
        if (o_data !== m_data || o_addr !== m_data[31:0] || o_id !== m_id || o_tag !== m_tag || o_err !== m_err)
          begin failures++;
          $display("FAIL rand_out[%0d]: data=%h id=%0b tag=%0d err=%0b expected %h/%0b/%0d/%0b",
                   k, o_data, o_id, o_tag, o_err, m_data, m_id, m_tag, m_err); end
      end
    end
    idle(); o_ready = 1; tick();
  endtask

  initial begin
    rst = 1; o_ready = 0;
    m_full = 0; m_data = '0; m_id = 0; m_tag = '0; m_err = 0; m_last = 1;
    idle();
    test_reset();
    test_add();
    test_alternate();
    test_sub_upper();
    test_hold();
    test_err();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
